brent_kung_subtractor_seq: RTL and testbench
============================================

BRENT_KUNG_SUBTRACTOR_SEQ -- requirements
Module: brent_kung_subtractor_seq

Interface
REQ-001 Parameter WIDTH, 12: addend/difference width; the sum is WIDTH+1 bits.
REQ-002 Parameter CHUNK, 4: bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  sum/addend presented.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 sum  input  WIDTH+1  13-bit adder result to invert.
REQ-008 addend  input  WIDTH  known addend.
REQ-009 out_valid  output  1  diff/err valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  recovered addend, equal to (sum - addend) mod 2^WIDTH.
REQ-012 err  output  1  sum is not reachable from the given addend (sum - addend is outside 0..2^WIDTH-1).

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-015 In IDLE, the block SHALL register sum, addend and borrow=0 on an edge with in_valid=1, set step=0 and move to CALC; otherwise it SHALL stay in IDLE.
REQ-016 In each CALC cycle, the block SHALL compute chunk[step] of diff as the sum chunk minus the addend chunk minus borrow, using CHUNK-bit arithmetic, LSB chunk first.
REQ-017 Also in each CALC cycle, the block SHALL register the borrow-out and increment step.
REQ-018 On the edge that completes chunk WIDTH/CHUNK-1, the block SHALL set err = (sum[WIDTH] XOR borrow_out) and move to DONE.
REQ-019 Latency: out_valid SHALL be 1 after exactly WIDTH/CHUNK edges following the accepting edge (3 for the defaults).
REQ-020 In DONE, diff and err SHALL hold stable while out_ready=0; in_valid SHALL be ignored.
REQ-021 In DONE with out_ready=1, the block SHALL move to IDLE on that edge; out_valid SHALL be 0 in the next cycle.
REQ-022 No new operand SHALL be accepted on the output-handshake edge; the minimum issue interval SHALL be WIDTH/CHUNK+2 cycles.
REQ-023 diff SHALL wrap modulo 2^WIDTH; err SHALL flag both underflow (sum < addend) and overflow (sum - addend >= 2^WIDTH).
REQ-024 Inputs SHALL be sampled only on the accepting edge; later changes to sum or addend SHALL NOT affect the result.
REQ-025 Chunk results not yet computed SHALL read 0 in diff during CALC; diff SHALL be qualified by out_valid only.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, in_ready=1 and out_valid=0.
REQ-027 rst=1 SHALL immediately clear diff, err, borrow, step and the operand registers to 0.
REQ-028 Reset during CALC or DONE SHALL abort the operation with no result emitted.
REQ-029 After reset release, the first rising edge with in_valid=1 SHALL accept operands.

Verification
REQ-030 Basic case: sum=13'h0579, addend=12'h456, out_ready=1 -> out_valid on the 3rd edge after acceptance, diff=12'h123, err=0.
REQ-031 Maximum case: sum=13'h1FFE, addend=12'hFFF -> diff=12'hFFF, err=0.
REQ-032 Underflow: sum=13'h0005, addend=12'h006 -> diff=12'hFFF, err=1.
REQ-033 Overflow: sum=13'h1000, addend=12'h000 -> diff=12'h000, err=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles while in_valid=1 with new data -> diff/err stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE next cycle, then accept.
REQ-035 Reset mid-operation: rst pulsed in the 2nd CALC cycle -> out_valid=0 and in_ready=1 immediately; the next accepted pair yields a correct result (e.g. 13'h0579/12'h456 -> 12'h123).

Source files
------------

// File: rtl/brent_kung_subtractor_seq_if.sv
// Operand/result handshake bundle for brent_kung_subtractor_seq.
//   in_valid/in_ready   : operand pair handshake (sum, addend)
//   out_valid/out_ready : result handshake (diff, err)
// Modports: slave = the subtractor, master = the block driving operands and consuming results.
interface brent_kung_subtractor_seq_if #(
  parameter int unsigned WIDTH = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             err;

  modport slave (
    input  in_valid, sum, addend, out_ready,
    output in_ready, out_valid, diff, err
  );

  modport master (
    output in_valid, sum, addend, out_ready,
    input  in_ready, out_valid, diff, err
  );
endinterface

// File: rtl/brent_kung_subtractor_seq.sv
// Sequential adder inverter: recovers diff = (sum - addend) mod 2^WIDTH, CHUNK bits per cycle,
// LSB chunk first, with a rippled borrow between cycles. err flags a sum that no WIDTH-bit
// value plus addend can produce (underflow or overflow of the subtraction).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave modport of brent_kung_subtractor_seq_if (operand and result handshakes)
// WIDTH must be an integer multiple of CHUNK.
module brent_kung_subtractor_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CHUNK = 4
) (
  input logic                         clk,
  input logic                         rst,
  brent_kung_subtractor_seq_if.slave  bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned StepW     = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NumChunks - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH-1:0] addend_q;
  logic             borrow_q;
  logic [StepW-1:0] step_q;
  logic [WIDTH-1:0] diff_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] sum_chunk;
  logic [CHUNK-1:0] add_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [CHUNK-1:0] diff_chunk;
  logic             borrow_out;

  // Select the operand chunk addressed by step_q.
  always_comb begin
    sum_chunk = '0;
    add_chunk = '0;
    for (int i = 0; i < NumChunks; i++) begin
      if (step_q == StepW'(i)) begin
        sum_chunk = sum_q[i*CHUNK +: CHUNK];
        add_chunk = addend_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // One guard bit: a negative chunk result leaves it set, which is exactly the borrow-out.
  always_comb begin
    chunk_res  = {1'b0, sum_chunk} - {1'b0, add_chunk} - {{CHUNK{1'b0}}, borrow_q};
    diff_chunk = chunk_res[CHUNK-1:0];
    borrow_out = chunk_res[CHUNK];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sum_q       <= '0;
      addend_q    <= '0;
      borrow_q    <= 1'b0;
      step_q      <= '0;
      diff_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            sum_q      <= bus.sum;
            addend_q   <= bus.addend;
            borrow_q   <= 1'b0;
            step_q     <= '0;
            // Uncomputed chunks must read zero while calculating.
            diff_q     <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          for (int i = 0; i < NumChunks; i++) begin
            if (step_q == StepW'(i)) diff_q[i*CHUNK +: CHUNK] <= diff_chunk;
          end
          borrow_q <= borrow_out;
          step_q   <= step_q + StepW'(1);
          if (step_q == LastStep) begin
            // Result fits only if the final borrow cancels the sum's carry bit.
            err_q       <= sum_q[WIDTH] ^ borrow_out;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_brent_kung_subtractor_seq.sv
module tb_brent_kung_subtractor_seq;

  localparam int unsigned W = 12;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  brent_kung_subtractor_seq_if #(.WIDTH(W)) bus ();

  brent_kung_subtractor_seq #(
    .WIDTH(W),
    .CHUNK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W:0]   sum;
    logic [W-1:0] addend;
    logic [W-1:0] diff;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Plain integer subtraction; err whenever the true difference leaves 0..2^W-1.
  function automatic void model(input logic [W:0] s, input logic [W-1:0] a,
                                output logic [W-1:0] d, output logic e);
    int r;
    r = int'(s) - int'(a);
    d = W'(r);
    e = (r < 0) || (r >= (1 << W));
  endfunction

  // Advance edge by edge (sampling 1 time unit later) until out_valid, at most 20 edges.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called 1 time unit after a rising edge with the DUT idle and out_ready=1.
  task automatic run_op(input logic [W:0] s, input logic [W-1:0] a, input string tag);
    logic [W-1:0] ed;
    logic         ee;
    int           lat;
    model(s, a, ed, ee);
    check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.sum      = s;
    bus.addend   = a;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.sum      = (W+1)'($urandom);
    bus.addend   = W'($urandom);
    check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " diff"}, 32'(bus.diff), 32'(ed));
    check({tag, " err"}, 32'(bus.err), 32'(ee));
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    vecs[0] = '{13'h0579, 12'h456, 12'h123, 1'b0};
    vecs[1] = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0};
    vecs[2] = '{13'h0005, 12'h006, 12'hFFF, 1'b1};
    vecs[3] = '{13'h1000, 12'h000, 12'h000, 1'b1};
    vecs[4] = '{13'h0000, 12'h000, 12'h000, 1'b0};
    vecs[5] = '{13'h0FFF, 12'h000, 12'hFFF, 1'b0};
    vecs[6] = '{13'h1FFF, 12'h000, 12'hFFF, 1'b1};
    vecs[7] = '{13'h0000, 12'hFFF, 12'h001, 1'b1};
    vecs[8] = '{13'h0800, 12'h801, 12'hFFF, 1'b1};
    vecs[9] = '{13'h1000, 12'h001, 12'hFFF, 1'b0};

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sum       = '0;
    bus.addend    = '0;

    // Reset state, asynchronous assertion between edges.
    #3 rst = 1'b1;
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset diff", 32'(bus.diff), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    #8 rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: expected values written from hand arithmetic, cross-checked by the model.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] md;
      logic         me;
      model(vecs[i].sum, vecs[i].addend, md, me);
      if (md !== vecs[i].diff || me !== vecs[i].err)
        $display("note: table entry %0d disagrees with model", i);
      run_op(vecs[i].sum, vecs[i].addend, $sformatf("vec%0d", i));
    end

    // Partial results during CALC: computed chunks appear, the rest read zero.
    bus.sum = 13'h0579; bus.addend = 12'h456; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.sum = 13'h1FFF; bus.addend = 12'h000;
    @(posedge clk); #1;
    check("partial chunk0", 32'(bus.diff), 32'h003);
    @(posedge clk); #1;
    check("partial chunk1", 32'(bus.diff), 32'h023);
    check("partial out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("partial done valid", 32'(bus.out_valid), 32'd1);
    check("partial done diff", 32'(bus.diff), 32'h123);
    @(posedge clk); #1;

    // Backpressure with competing operands held on the input.
    bus.out_ready = 1'b0;
    bus.sum = 13'h0579; bus.addend = 12'h456; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.sum = 13'h0005; bus.addend = 12'h006;
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd3);
    check("bp diff", 32'(bus.diff), 32'h123);
    check("bp err", 32'(bus.err), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp hold diff", 32'(bus.diff), 32'h123);
      check("bp hold err", 32'(bus.err), 32'd0);
      check("bp hold in_ready", 32'(bus.in_ready), 32'd0);
      check("bp hold out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp no accept on handshake", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp next accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp next latency", 32'(lat), 32'd3);
    check("bp next diff", 32'(bus.diff), 32'hFFF);
    check("bp next err", 32'(bus.err), 32'd1);
    @(posedge clk); #1;

    // Reset in the second CALC cycle aborts the operation.
    bus.sum = 13'h1FFE; bus.addend = 12'h001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("midreset no result", 32'(bus.out_valid), 32'd0);
    end
    run_op(13'h0579, 12'h456, "after reset");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [W:0]   s;
      logic [W-1:0] a;
      s = (W+1)'($urandom_range(0, (1 << (W+1)) - 1));
      a = W'($urandom_range(0, (1 << W) - 1));
      run_op(s, a, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
